// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, default line rates and
// the bit-period helpers shared with the receive side.
package uart_pkg;

  localparam int unsigned DefaultClkFreq = 50_000_000;
  localparam int unsigned DefaultBaud    = 115_200;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StDone
  } tx_state_e;

  // Clocks per bit; integer truncation is the only timing error on the line.
  function automatic int unsigned calc_div(input int unsigned clk_freq,
                                           input int unsigned baud);
    return clk_freq / baud;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned div);
    return (div < 2) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period divider: counts 0..DIV-1 while enabled and flags the last count of each bit.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int unsigned DIV = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int unsigned     CntW   = cnt_width(DIV);
  localparam logic [CntW-1:0] CntMax = CntW'(DIV - 1);

  logic [CntW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == CntMax) ? '0 : cnt + 1'b1;
    end
  end

  assign tick = en && (cnt == CntMax);

endmodule

// File: rtl/uart_byte_tx.sv
// Byte-at-a-time UART transmitter: start bit, 8 data bits LSB first, optional
// parity, 1 or 2 stop bits, then a one-cycle is_done pulse back to the sequencer.
module uart_byte_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = DefaultClkFreq,
  parameter int unsigned BAUD       = DefaultBaud,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] uart_data,
  input  logic       is_send,
  output logic       is_done,
  output logic       uart_tx,
  output logic       busy
);

  localparam int unsigned DIV      = calc_div(CLK_FREQ, BAUD);
  localparam logic [2:0]  LastStop = 3'(STOP_BITS - 1);

  if (DIV < 2) begin : g_div_check
    $error("uart_byte_tx: CLK_FREQ/BAUD must be at least 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_stop_check
    $error("uart_byte_tx: STOP_BITS must be 1 or 2");
  end

  tx_state_e  state;
  logic [2:0] bit_idx;
  logic [7:0] shift;
  logic       parity_bit;
  logic       tick;
  logic       start;

  assign start = (state == StIdle) && is_send;

  uart_baud_tick #(
    .DIV(DIV)
  ) u_baud_tick (
    .clk (clk),
    .rst (rst),
    .clr (start),
    .en  (state != StIdle),
    .tick(tick)
  );

  // Outputs are assigned alongside each state change so the line level,
  // busy and is_done always line up with the state they describe.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= StIdle;
      bit_idx    <= '0;
      shift      <= '0;
      parity_bit <= 1'b0;
      uart_tx    <= 1'b1;
      is_done    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      is_done <= 1'b0;
      unique case (state)
        StIdle: begin
          uart_tx <= 1'b1;
          busy    <= 1'b0;
          if (is_send) begin
            shift      <= uart_data;
            parity_bit <= (^uart_data) ^ (PARITY_ODD != 0);
            bit_idx    <= '0;
            state      <= StStart;
            uart_tx    <= 1'b0;
            busy       <= 1'b1;
          end
        end
        StStart: begin
          if (tick) begin
            state   <= StData;
            uart_tx <= shift[0];
          end
        end
        StData: begin
          if (tick) begin
            if (bit_idx == 3'd7) begin
              bit_idx <= '0;
              if (PARITY_EN != 0) begin
                state   <= StParity;
                uart_tx <= parity_bit;
              end else begin
                state   <= StStop;
                uart_tx <= 1'b1;
              end
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shift   <= shift >> 1;
              uart_tx <= shift[1];
            end
          end
        end
        StParity: begin
          if (tick) begin
            state   <= StStop;
            uart_tx <= 1'b1;
          end
        end
        StStop: begin
          // bit_idx is reused to count stop-bit periods.
          if (tick) begin
            if (bit_idx == LastStop) begin
              bit_idx <= '0;
              state   <= StDone;
              is_done <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end
        end
        StDone: begin
          state   <= StIdle;
          busy    <= 1'b0;
          uart_tx <= 1'b1;
        end
        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_byte_tx.sv
// Bench for uart_byte_tx: three parameterisations, a per-cycle waveform model
// built from the frame bit list, and directed literal checks at key cycles.
`timescale 1ns/1ps
module tb_uart_byte_tx;

  localparam int unsigned ClkFreq = 1_000_000;
  localparam int unsigned Baud    = 100_000;
  localparam int          Div     = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] send;
  logic [7:0] data [3];
  logic [2:0] tx_w;
  logic [2:0] busy_w;
  logic [2:0] done_w;

  int n_pass = 0;
  int n_total = 0;
  int done_cnt [3] = '{default: 0};

  always #5 clk = ~clk;

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask

  // g=0: no parity, 1 stop; g=1: even parity, 1 stop; g=2: odd parity, 2 stop.
  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned Pe = (g == 0) ? 0 : 1;
    localparam int unsigned Po = (g == 2) ? 1 : 0;
    localparam int unsigned Sb = (g == 2) ? 2 : 1;

    uart_byte_tx #(
      .CLK_FREQ  (ClkFreq),
      .BAUD      (Baud),
      .PARITY_EN (Pe),
      .PARITY_ODD(Po),
      .STOP_BITS (Sb)
    ) dut (
      .clk      (clk),
      .rst      (rst),
      .uart_data(data[g]),
      .is_send  (send[g]),
      .is_done  (done_w[g]),
      .uart_tx  (tx_w[g]),
      .busy     (busy_w[g])
    );

    // Expected {uart_tx, busy, is_done} for each upcoming cycle.
    logic [2:0] q [$];
    logic [2:0] exp_o = 3'b100;
    bit         valid = 1'b0;

    always @(posedge clk) begin
      bit lv [$];
      lv.delete();
      if (!rst) begin
        q.delete();
        exp_o = 3'b100;
        valid = 1'b1;
      end else begin
        if (q.size() == 0 && send[g] === 1'b1) begin
          lv.push_back(1'b0);
          for (int i = 0; i < 8; i++) lv.push_back(data[g][i]);
          if (Pe != 0) lv.push_back((($countones(data[g]) % 2) == 1) ^ (Po != 0));
          for (int s = 0; s < int'(Sb); s++) lv.push_back(1'b1);
          foreach (lv[i]) for (int c = 0; c < Div; c++) q.push_back({lv[i], 2'b10});
          q.push_back(3'b111);
          q.push_back(3'b100);
        end
        exp_o = (q.size() != 0) ? q.pop_front() : 3'b100;
      end
    end

    always @(negedge clk) begin
      if (valid) begin
        check_bit($sformatf("model_tx%0d", g), tx_w[g], exp_o[2]);
        check_bit($sformatf("model_busy%0d", g), busy_w[g], exp_o[1]);
        check_bit($sformatf("model_done%0d", g), done_w[g], exp_o[0]);
        if (done_w[g] === 1'b1) done_cnt[g]++;
      end
    end
  end

  initial begin
    int nfr;
    int len1;
    int len2;
    rst  = 1'b0;
    send = '0;
    foreach (data[i]) data[i] = 8'h00;

    // Reset held with a pending request.
    @(negedge clk);
    data[0] = 8'hA5;
    send[0] = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_bit("rst_tx", tx_w[0], 1'b1);
      check_bit("rst_busy", busy_w[0], 1'b0);
      check_bit("rst_done", done_w[0], 1'b0);
    end
    rst = 1'b1;

    // 0xA5 then back-to-back 0x3C.
    nfr = 0;
    for (int k = 1; k <= 210; k++) begin
      @(negedge clk);
      case (k)
        1:   begin check_bit("a5_start_first", tx_w[0], 1'b0); check_bit("a5_busy", busy_w[0], 1'b1); end
        10:  check_bit("a5_start_last", tx_w[0], 1'b0);
        11:  check_bit("a5_bit0", tx_w[0], 1'b1);
        21:  check_bit("a5_bit1", tx_w[0], 1'b0);
        90:  check_bit("a5_bit7", tx_w[0], 1'b1);
        91:  check_bit("a5_stop", tx_w[0], 1'b1);
        100: check_bit("a5_no_early_done", done_w[0], 1'b0);
        101: begin check_bit("a5_done", done_w[0], 1'b1); check_bit("a5_done_busy", busy_w[0], 1'b1); end
        102: begin check_bit("gap_busy", busy_w[0], 1'b0); check_bit("gap_tx", tx_w[0], 1'b1); end
        103: begin check_bit("3c_start", tx_w[0], 1'b0); check_bit("3c_busy", busy_w[0], 1'b1); end
        113: check_bit("3c_bit0", tx_w[0], 1'b0);
        133: check_bit("3c_bit2", tx_w[0], 1'b1);
        203: check_bit("3c_done", done_w[0], 1'b1);
        default: ;
      endcase
      if (done_w[0] === 1'b1) begin
        nfr++;
        if (nfr == 1) data[0] = 8'h3C;
        else send[0] = 1'b0;
      end
    end
    check_int("two_frames", done_cnt[0], 2);

    // Parity variants with 0x07.
    data[1] = 8'h07;
    data[2] = 8'h07;
    send[1] = 1'b1;
    send[2] = 1'b1;
    len1 = 0;
    len2 = 0;
    for (int k = 1; k <= 135; k++) begin
      @(negedge clk);
      if (busy_w[1] === 1'b1 && done_w[1] !== 1'b1) len1++;
      if (busy_w[2] === 1'b1 && done_w[2] !== 1'b1) len2++;
      if (k == 95) begin
        check_bit("parity_even", tx_w[1], 1'b1);
        check_bit("parity_odd", tx_w[2], 1'b0);
      end
      if (k == 111) check_bit("done_even_1stop", done_w[1], 1'b1);
      if (k == 121) check_bit("done_odd_2stop", done_w[2], 1'b1);
      if (done_w[1] === 1'b1) send[1] = 1'b0;
      if (done_w[2] === 1'b1) send[2] = 1'b0;
    end
    check_int("len_even_1stop", len1, 110);
    check_int("len_odd_2stop", len2, 120);

    // Reset during data bit 4 of 0xFF, then a clean 0x55.
    data[0] = 8'hFF;
    send[0] = 1'b1;
    for (int k = 1; k <= 70; k++) begin
      @(negedge clk);
      if (k == 55) begin
        check_bit("ff_bit4", tx_w[0], 1'b1);
        rst     = 1'b0;
        send[0] = 1'b0;
      end
      if (k == 56) begin
        check_bit("midrst_tx", tx_w[0], 1'b1);
        check_bit("midrst_busy", busy_w[0], 1'b0);
        rst = 1'b1;
      end
    end
    check_int("midrst_no_done", done_cnt[0], 2);

    data[0] = 8'h55;
    send[0] = 1'b1;
    for (int k = 1; k <= 105; k++) begin
      @(negedge clk);
      if (k == 11) check_bit("55_bit0", tx_w[0], 1'b1);
      if (k == 21) check_bit("55_bit1", tx_w[0], 1'b0);
      if (done_w[0] === 1'b1) send[0] = 1'b0;
    end
    check_int("55_done", done_cnt[0], 3);

    // Input changes mid-frame must not disturb 0x12.
    data[0] = 8'h12;
    send[0] = 1'b1;
    for (int k = 1; k <= 110; k++) begin
      @(negedge clk);
      if (k == 35) begin
        data[0] = 8'hEE;
        send[0] = 1'b0;
      end
      if (k == 55)  check_bit("12_bit4_held", tx_w[0], 1'b1);
      if (k == 101) check_bit("12_done", done_w[0], 1'b1);
      if (k == 102) check_bit("12_idle_busy", busy_w[0], 1'b0);
    end
    check_int("12_done_once", done_cnt[0], 4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
